// File: rtl/direct_map_cache.sv
// ---------------------------------------------------------------------------
// direct_map_cache
//
// Direct-mapped, one-word-per-line cache storage core. Lookup is purely
// combinational from addr; one line may be updated per rising clock edge,
// either by a refill from memory or by a CPU store into a hit line.
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   reset           : asynchronous active-low reset, clears every line
//   addr            : lookup/write address (byte offset ignored)
//   hit             : indexed line valid and tag matches addr
//   dirty           : indexed line valid and dirty (independent of tag match)
//   data            : word stored in the indexed line
//   write_data      : data to write
//   write_strb      : byte enables, bit n covers write_data[8n+7:8n]
//   write_valid     : perform a write at the next rising edge
//   write_access    : 0 = refill from memory, 1 = CPU store
//   invalidate_addr : address of the line currently resident at the index
// ---------------------------------------------------------------------------
module direct_map_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  output logic        hit,
  output logic        dirty,
  output logic [31:0] data,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strb,
  input  logic        write_valid,
  input  logic        write_access,
  output logic [31:0] invalidate_addr
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 32 - IDX - 2;

  // Per-line state. Kept in flops rather than block RAM because reset must
  // clear every line asynchronously and lookups are combinational.
  logic             valid_reg [LINES];
  logic             dirty_reg [LINES];
  logic [TAG_W-1:0] tag_reg   [LINES];
  logic [31:0]      data_reg  [LINES];

  logic [IDX-1:0]   addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             line_valid;
  logic             line_dirty;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic [31:0]      merge_base;
  logic [31:0]      merged_word;

  // Byte offset does not take part in the lookup.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr[1:0];

  assign addr_idx = addr[IDX+1:2];
  assign addr_tag = addr[31:IDX+2];

  assign line_valid = valid_reg[addr_idx];
  assign line_dirty = dirty_reg[addr_idx];
  assign line_tag   = tag_reg[addr_idx];
  assign line_data  = data_reg[addr_idx];

  assign hit             = line_valid && (line_tag == addr_tag);
  assign dirty           = line_valid && line_dirty;
  assign data            = line_data;
  assign invalidate_addr = {line_tag, addr_idx, 2'b00};

  // Unstrobed bytes keep the old word when the line already holds this
  // address (refill hit or store hit); a refill that evicts or fills an
  // empty line starts from zero so no stale bytes from the victim survive.
  assign merge_base = (!write_access && !hit) ? 32'h0 : line_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
      assign merged_word[8*gi +: 8] = write_strb[gi] ? write_data[8*gi +: 8]
                                                     : merge_base[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++) begin
        valid_reg[i] <= 1'b0;
        dirty_reg[i] <= 1'b0;
        tag_reg[i]   <= '0;
        data_reg[i]  <= 32'h0;
      end
    end else if (write_valid) begin
      if (!write_access) begin
        // Refill: always (re)allocates the indexed line as clean.
        valid_reg[addr_idx] <= 1'b1;
        dirty_reg[addr_idx] <= 1'b0;
        tag_reg[addr_idx]   <= addr_tag;
        data_reg[addr_idx]  <= merged_word;
      end else if (hit) begin
        // Store: no write-allocate, a miss leaves the line untouched.
        dirty_reg[addr_idx] <= 1'b1;
        data_reg[addr_idx]  <= merged_word;
      end
    end
  end

endmodule

// File: tb/tb_direct_map_cache.sv
// ---------------------------------------------------------------------------
// tb_direct_map_cache
//
// Directed test of direct_map_cache (LINES = 64). Stimulus pushes the
// expected lookup result into a queue and raises chk_req; a monitor process
// samples the DUT on the falling clock edge and compares against the head
// of the queue.
// ---------------------------------------------------------------------------
module tb_direct_map_cache;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        hit;
  logic        dirty;
  logic [31:0] data;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        write_valid;
  logic        write_access;
  logic [31:0] invalidate_addr;

  direct_map_cache #(.LINES(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .addr            (addr),
    .hit             (hit),
    .dirty           (dirty),
    .data            (data),
    .write_data      (write_data),
    .write_strb      (write_strb),
    .write_valid     (write_valid),
    .write_access    (write_access),
    .invalidate_addr (invalidate_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic        e_hit;
    logic        e_dirty;
    logic [31:0] e_data;
    logic        chk_data;
    logic [31:0] e_inv;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req;
  int   checks;
  int   errors;

  // Monitor: compares the DUT lookup against the oldest expectation.
  always @(negedge clk) begin
    if (chk_req && exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (hit === e.e_hit) && (dirty === e.e_dirty) &&
           (invalidate_addr === e.e_inv) &&
           (!e.chk_data || (data === e.e_data));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s addr=%h: got hit=%0b dirty=%0b data=%h inv=%h, required hit=%0b dirty=%0b data=%h inv=%h",
                 e.name, e.a, hit, dirty, data, invalidate_addr,
                 e.e_hit, e.e_dirty, e.e_data, e.e_inv);
      end else begin
        $display("ok   %s addr=%h hit=%0b dirty=%0b data=%h inv=%h",
                 e.name, e.a, hit, dirty, data, invalidate_addr);
      end
    end
  end

  // Queue an expectation and let the monitor sample it at the next negedge.
  task automatic expect_line(input string nm, input logic [31:0] a,
                             input logic eh, input logic ed,
                             input logic [31:0] edata, input logic cd,
                             input logic [31:0] einv);
    exp_t e;
    e.name = nm; e.a = a; e.e_hit = eh; e.e_dirty = ed;
    e.e_data = edata; e.chk_data = cd; e.e_inv = einv;
    addr = a;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  // One write sampled at the next rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] strb, input logic acc);
    @(posedge clk);
    #1;
    addr = a; write_data = wd; write_strb = strb;
    write_access = acc; write_valid = 1'b1;
    @(posedge clk);
    #1 write_valid = 1'b0;
    $display("write addr=%h data=%h strb=%b access=%0b", a, wd, strb, acc);
  endtask

  initial begin
    reset = 1'b0; addr = 32'h0; write_data = 32'h0; write_strb = 4'h0;
    write_valid = 1'b0; write_access = 1'b0; chk_req = 1'b0;
    checks = 0; errors = 0;

    // A write presented during reset must be ignored.
    write_valid = 1'b1; addr = 32'h0000_0010; write_data = 32'hFFFF_FFFF;
    write_strb = 4'hF;
    repeat (3) @(posedge clk);
    #1 write_valid = 1'b0;
    reset = 1'b1;

    // Sweep every index: empty cache.
    for (int i = 0; i < 64; i++)
      expect_line("sweep_after_reset", 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4));

    // Refill and byte-offset aliasing.
    do_write(32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0);
    expect_line("refill_hit", 32'h0000_1004, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_1004);
    expect_line("byte_offset_hit", 32'h0000_1005, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_1004);

    // Store hit, one byte.
    do_write(32'h0000_1004, 32'h0000_00AA, 4'b0001, 1'b1);
    expect_line("store_hit", 32'h0000_1004, 1'b1, 1'b1, 32'hDEAD_BEAA, 1'b1, 32'h0000_1004);

    // Store miss to an alias: no change.
    do_write(32'h0000_2004, 32'h5555_5555, 4'hF, 1'b1);
    expect_line("store_miss_alias", 32'h0000_2004, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_1004);
    expect_line("store_miss_untouched", 32'h0000_1004, 1'b1, 1'b1, 32'hDEAD_BEAA, 1'b1, 32'h0000_1004);

    // Refill the alias: evicts previous occupant.
    do_write(32'h0000_2004, 32'h1234_5678, 4'hF, 1'b0);
    expect_line("evict_refill", 32'h0000_2004, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 32'h0000_2004);
    expect_line("evicted_misses", 32'h0000_1004, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_2004);

    // Partial refill on a miss clears unstrobed bytes.
    do_write(32'h0000_3008, 32'hAABB_CCDD, 4'b0101, 1'b0);
    expect_line("partial_refill_miss", 32'h0000_3008, 1'b1, 1'b0, 32'h00BB_00DD, 1'b1, 32'h0000_3008);
    // Partial refill on a hit keeps unstrobed bytes.
    do_write(32'h0000_3008, 32'h1122_3344, 4'b1010, 1'b0);
    expect_line("partial_refill_hit", 32'h0000_3008, 1'b1, 1'b0, 32'h11BB_33DD, 1'b1, 32'h0000_3008);
    // Store hit with no strobes still dirties the line.
    do_write(32'h0000_3008, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    expect_line("store_zero_strb", 32'h0000_3008, 1'b1, 1'b1, 32'h11BB_33DD, 1'b1, 32'h0000_3008);
    // Refill miss with no strobes: allocated, clean, zero data.
    do_write(32'h0000_4008, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    expect_line("refill_zero_strb", 32'h0000_4008, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_4008);

    // write_valid low: nothing changes even with other inputs active.
    @(posedge clk);
    #1 addr = 32'h0000_4008; write_data = 32'hCAFE_F00D; write_strb = 4'hF;
    write_access = 1'b0; write_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_line("no_write_valid", 32'h0000_4008, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_4008);

    // Pending write: old contents visible until the edge.
    @(posedge clk);
    #1 write_data = 32'h0BAD_F00D; write_strb = 4'hF; write_access = 1'b0;
    write_valid = 1'b1;
    expect_line("before_edge", 32'h0000_500C, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_000C);
    @(posedge clk);
    #1 write_valid = 1'b0;
    expect_line("after_edge", 32'h0000_500C, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0000_500C);

    // Line written during reset earlier must still be empty.
    expect_line("write_in_reset_ignored", 32'h0000_0010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0010);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 reset = 1'b0;
    expect_line("async_reset_2004", 32'h0000_2004, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0004);
    expect_line("async_reset_3008", 32'h0000_3008, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0008);
    #1 reset = 1'b1;
    expect_line("post_reset_1004", 32'h0000_1004, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0004);
    expect_line("post_reset_500c", 32'h0000_500C, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_000C);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/direct_map_cache.md
# direct_map_cache

Direct-mapped, one-word-per-line cache array used as the storage core of the instruction and data caches. Lookup is combinational: from `addr` it reports hit, the stored word, the line's dirty state and the address of the resident line. On a clock edge it accepts either a refill from memory or a CPU store into a hit line. The surrounding cache controller owns all memory handshaking and sequencing.

## Interface
- `LINES`, default 64: number of lines. Power of two, ≥ 2. `IDX = log2(LINES)`.
- `clk  input  1`: single clock. All state updates on the rising edge; the instantiating cache may drive it inverted.
- `reset  input  1`: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `addr  input  32`: lookup/write address. Byte offset = `addr[1:0]` (ignored), index = `addr[IDX+1:2]`, tag = `addr[31:IDX+2]`.
- `hit  output  1`: indexed line valid and stored tag equals `addr` tag.
- `dirty  output  1`: indexed line valid and dirty, regardless of tag match.
- `data  output  32`: word stored in the indexed line. Meaningful only when `hit`=1.
- `write_data  input  32`: data to write.
- `write_strb  input  4`: byte enables. Bit n covers `write_data[8n+7:8n]`.
- `write_valid  input  1`: perform a write at the next rising edge.
- `write_access  input  1`: 0 = refill from memory, 1 = CPU store.
- `invalidate_addr  output  32`: address of the resident line at the indexed slot, `{stored_tag, index, 2'b00}`. This is the write-back/victim address.

## Operation
- Per-line state: valid bit, dirty bit, tag (32−IDX−2 bits), 32-bit data word.
- Lookup outputs are purely combinational from `addr` and the current array state. There are no read-side registers.
- Refill (`write_valid`=1, `write_access`=0):
  - Indexed line gets tag ← `addr` tag, valid ← 1, dirty ← 0.
  - Strobed bytes take `write_data`.
  - If the line was a hit before the edge, unstrobed bytes keep their old value. Otherwise unstrobed bytes are cleared to 0.
- Store (`write_valid`=1, `write_access`=1):
  - On hit, strobed bytes take `write_data` and dirty ← 1. Tag and valid are unchanged.
  - On miss, nothing changes (no write-allocate). The controller must refill first.
- `write_strb`=0 with `write_valid`=1: a refill still sets tag/valid/dirty. A store hit still sets dirty.
- `write_valid`=0: no state change.
- Only the one indexed line is modified per edge.

## Timing
- Reset asserted (low) asynchronously clears every line's valid, dirty, tag and data to 0. Outputs then read `hit`=0, `dirty`=0, `data`=0, `invalidate_addr`={0, index, 00}. Writes are ignored while in reset.
- Read latency is 0 cycles. Outputs settle combinationally after any `addr` change.
- Write latency: a write sampled at a rising edge is visible on the outputs immediately after that edge, in the same cycle if `addr` is held.
- Write and lookup of the same line in one cycle: outputs show pre-edge contents until the edge.
- Reset deasserting mid-operation: the first edge with `reset` high may perform a write.
- Aliases (same index, different tag) always evict. `invalidate_addr` and `dirty` reflect the occupant before the refill edge.

## Test plan
- Reset, then sweep `addr` 0x0000_0000…0x0000_00FC: required `hit`=0, `dirty`=0, `data`=0 everywhere.
- Refill `addr`=0x0000_1004, `write_data`=0xDEADBEEF, strb=1111. Next cycle, same addr: required `hit`=1, `data`=0xDEADBEEF, `dirty`=0, `invalidate_addr`=0x0000_1004. Addr 0x0000_1005 also hits (byte offset ignored).
- After that refill, store at 0x0000_1004 with `write_data`=0x0000_00AA, strb=0001: required `data`=0xDEADBEAA, `dirty`=1.
- Store at miss 0x0000_2004 (LINES=64, same index as 0x1004): no change, `hit`=0, `dirty`=1, `invalidate_addr`=0x0000_1004.
- Refill 0x0000_2004 with 0x12345678, strb=1111: required `hit`=1, `dirty`=0, `invalidate_addr`=0x0000_2004. Address 0x0000_1004 now misses.
- Assert reset asynchronously between edges after fills: all outputs return to reset values immediately, and previously filled addresses miss.
